// File: rtl/isq_slot_ctrl_if.sv
// Handshake and status bundle between the issue-queue slot controller and its neighbours.
// slave is the controller side; master is the upstream / age-logic / storage side.
interface isq_slot_ctrl_if #(
    parameter int unsigned ISSUE_QUEUE_DEPTH = 8,
    parameter int unsigned ISSUE_QUEUE_LOG   = 3
);
    logic                         enq_valid;
    logic                         enq_ready;
    logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_wren_oh;
    logic [ISSUE_QUEUE_LOG-1:0]   enq_ptr;
    logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_valid;
    logic                         oldest_found;
    logic [ISSUE_QUEUE_DEPTH-1:0] oldest_idx_oh;
    logic                         deq_ready;
    logic                         deq_fire;
    logic [ISSUE_QUEUE_LOG-1:0]   deq_ptr;
    logic [ISSUE_QUEUE_DEPTH-1:0] iq_entries_clear_entry;
    logic                         flush;
    logic [ISSUE_QUEUE_LOG:0]     count;
    logic                         full;
    logic                         empty;
    logic                         protocol_err;

    modport slave (
        input  enq_valid, oldest_found, oldest_idx_oh, deq_ready, flush,
        output enq_ready, iq_entries_wren_oh, enq_ptr, iq_entries_valid, deq_fire, deq_ptr,
               iq_entries_clear_entry, count, full, empty, protocol_err
    );

    modport master (
        output enq_valid, oldest_found, oldest_idx_oh, deq_ready, flush,
        input  enq_ready, iq_entries_wren_oh, enq_ptr, iq_entries_valid, deq_fire, deq_ptr,
               iq_entries_clear_entry, count, full, empty, protocol_err
    );
endinterface

// File: rtl/isq_slot_ctrl.sv
// Issue-queue slot controller: owns the valid vector, allocates the lowest free slot,
// fires dequeues from the age logic's selection and sequences flush recovery.
module isq_slot_ctrl #(
    parameter int unsigned ISSUE_QUEUE_DEPTH = 8,
    parameter int unsigned ISSUE_QUEUE_LOG   = 3,
    parameter int unsigned FLUSH_CYCLES      = 2
) (
    input logic            clock,
    input logic            reset,
    isq_slot_ctrl_if.slave bus
);
    localparam int unsigned Depth = ISSUE_QUEUE_DEPTH;
    localparam int unsigned PtrW  = ISSUE_QUEUE_LOG;
    localparam int unsigned CntW  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e            state_q;
    logic [CntW-1:0]   rcnt_q;
    logic [Depth-1:0]  valid_q;
    logic [PtrW:0]     count_q;
    logic              err_q;

    logic              run, full, empty, enq_ready, enq_fire, deq_fire, sel_ok;
    logic [PtrW-1:0]   enq_ptr, deq_ptr;
    logic [Depth-1:0]  wren_oh, clear_oh, sel;

    always_comb begin
        full      = (count_q == (PtrW+1)'(Depth));
        empty     = (count_q == '0);
        run       = (state_q == StRun);
        enq_ready = run & ~full & ~bus.flush;
        enq_fire  = bus.enq_valid & enq_ready;

        // Downward scan leaves the lowest free index; stays 0 when full.
        enq_ptr = '0;
        for (int i = int'(Depth) - 1; i >= 0; i--) begin
            if (!valid_q[i]) enq_ptr = PtrW'(i);
        end
        wren_oh = enq_fire ? (Depth'(1) << enq_ptr) : '0;

        // Selection must be exactly one bit and point at an occupied entry.
        sel    = bus.oldest_idx_oh;
        sel_ok = (sel != '0) && ((sel & (sel - Depth'(1))) == '0) && ((sel & ~valid_q) == '0);

        deq_fire = run & ~bus.flush & bus.oldest_found & bus.deq_ready & sel_ok;
        deq_ptr  = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (sel[i]) deq_ptr = deq_ptr | PtrW'(i);
        end
        clear_oh = deq_fire ? sel : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            rcnt_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (bus.oldest_found && !sel_ok) err_q <= 1'b1;
            if (bus.flush) begin
                state_q <= StFlush;
                rcnt_q  <= CntW'(FLUSH_CYCLES);
                valid_q <= '0;
                count_q <= '0;
            end else begin
                valid_q <= (valid_q | wren_oh) & ~clear_oh;
                count_q <= count_q + (PtrW+1)'(enq_fire) - (PtrW+1)'(deq_fire);
                if (state_q == StFlush) begin
                    if (rcnt_q <= CntW'(1)) begin
                        state_q <= StRun;
                        rcnt_q  <= '0;
                    end else begin
                        rcnt_q <= rcnt_q - CntW'(1);
                    end
                end
            end
        end
    end

    assign bus.enq_ready              = enq_ready;
    assign bus.iq_entries_wren_oh     = wren_oh;
    assign bus.enq_ptr                = enq_ptr;
    assign bus.iq_entries_valid       = valid_q;
    assign bus.deq_fire               = deq_fire;
    assign bus.deq_ptr                = deq_ptr;
    assign bus.iq_entries_clear_entry = clear_oh;
    assign bus.count                  = count_q;
    assign bus.full                   = full;
    assign bus.empty                  = empty;
    assign bus.protocol_err           = err_q;
endmodule

// File: tb/tb_isq_slot_ctrl.sv
// Scoreboard bench for isq_slot_ctrl: expectations are queued as each cycle's stimulus is
// driven, then popped and compared against the DUT at the following falling edge.
module tb_isq_slot_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    isq_slot_ctrl_if #(.ISSUE_QUEUE_DEPTH(8), .ISSUE_QUEUE_LOG(3)) bus ();

    isq_slot_ctrl #(
        .ISSUE_QUEUE_DEPTH(8),
        .ISSUE_QUEUE_LOG  (3),
        .FLUSH_CYCLES     (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef enum int {
        SigEnqReady, SigWren, SigEnqPtr, SigValid, SigDeqFire, SigDeqPtr,
        SigClear, SigCount, SigFull, SigEmpty, SigErr
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SigEnqReady: return 32'(bus.enq_ready);
            SigWren:     return 32'(bus.iq_entries_wren_oh);
            SigEnqPtr:   return 32'(bus.enq_ptr);
            SigValid:    return 32'(bus.iq_entries_valid);
            SigDeqFire:  return 32'(bus.deq_fire);
            SigDeqPtr:   return 32'(bus.deq_ptr);
            SigClear:    return 32'(bus.iq_entries_clear_entry);
            SigCount:    return 32'(bus.count);
            SigFull:     return 32'(bus.full);
            SigEmpty:    return 32'(bus.empty);
            default:     return 32'(bus.protocol_err);
        endcase
    endfunction

    task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic drive(input logic ev, input logic fl, input logic of,
                         input logic [7:0] oh, input logic dr);
        bus.enq_valid     = ev;
        bus.flush         = fl;
        bus.oldest_found  = of;
        bus.oldest_idx_oh = oh;
        bus.deq_ready     = dr;
    endtask

    // Compare at the falling edge, then step to just after the next rising edge.
    task automatic cycle();
        @(negedge clock);
        drain();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset state
        expect_sig("rst_valid", SigValid, 0);
        expect_sig("rst_count", SigCount, 0);
        expect_sig("rst_enq_ready", SigEnqReady, 1);
        expect_sig("rst_full", SigFull, 0);
        expect_sig("rst_empty", SigEmpty, 1);
        expect_sig("rst_deq_fire", SigDeqFire, 0);
        expect_sig("rst_wren", SigWren, 0);
        expect_sig("rst_clear", SigClear, 0);
        expect_sig("rst_err", SigErr, 0);
        cycle();
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Fill in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            expect_sig($sformatf("fill_ptr%0d", i), SigEnqPtr, i);
            expect_sig($sformatf("fill_wren%0d", i), SigWren, 32'(1) << i);
            expect_sig($sformatf("fill_count%0d", i), SigCount, i);
            cycle();
        end
        expect_sig("full_full", SigFull, 1);
        expect_sig("full_count", SigCount, 8);
        expect_sig("full_enq_ready", SigEnqReady, 0);
        expect_sig("full_wren", SigWren, 0);
        expect_sig("full_valid", SigValid, 8'hFF);

        // Dequeue entry 3 from a full queue while upstream is still offering
        drive(1'b1, 1'b0, 1'b1, 8'h08, 1'b1);
        expect_sig("fdeq_fire", SigDeqFire, 1);
        expect_sig("fdeq_ptr", SigDeqPtr, 3);
        expect_sig("fdeq_clear", SigClear, 8'h08);
        expect_sig("fdeq_enq_ready", SigEnqReady, 0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("fdeq_next_ptr", SigEnqPtr, 3);
        expect_sig("fdeq_next_ready", SigEnqReady, 1);
        expect_sig("fdeq_next_count", SigCount, 7);
        expect_sig("fdeq_next_valid", SigValid, 8'hF7);
        cycle();

        // Flush, then re-flush on the second recovery cycle
        drive(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
        expect_sig("fl1_deq_fire", SigDeqFire, 0);
        expect_sig("fl1_wren", SigWren, 0);
        expect_sig("fl1_enq_ready", SigEnqReady, 0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("fl1_valid", SigValid, 0);
        expect_sig("fl1_count", SigCount, 0);
        expect_sig("fl1_rec1_ready", SigEnqReady, 0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        expect_sig("fl2_pulse_ready", SigEnqReady, 0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("fl2_rec1_ready", SigEnqReady, 0);
        cycle();
        expect_sig("fl2_rec2_ready", SigEnqReady, 0);
        cycle();
        // Back in RUN: six enqueues give valid = 0x3F
        for (int i = 0; i < 6; i++) begin
            expect_sig($sformatf("refill_ready%0d", i), SigEnqReady, 1);
            expect_sig($sformatf("refill_wren%0d", i), SigWren, 32'(1) << i);
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("pre_fl_valid", SigValid, 8'h3F);
        expect_sig("pre_fl_count", SigCount, 6);
        cycle();

        // Single flush pulse from valid = 0x3F
        drive(1'b1, 1'b1, 1'b1, 8'h04, 1'b1);
        expect_sig("fl3_deq_fire", SigDeqFire, 0);
        expect_sig("fl3_clear", SigClear, 0);
        expect_sig("fl3_wren", SigWren, 0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("fl3_valid", SigValid, 0);
        expect_sig("fl3_count", SigCount, 0);
        expect_sig("fl3_rec1_ready", SigEnqReady, 0);
        cycle();
        expect_sig("fl3_rec2_ready", SigEnqReady, 0);
        cycle();
        expect_sig("fl3_run_ready", SigEnqReady, 1);

        // Four enqueues, then simultaneous enq into slot 4 and deq of entry 1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            cycle();
        end
        drive(1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
        expect_sig("sim_pre_valid", SigValid, 8'h0F);
        expect_sig("sim_pre_count", SigCount, 4);
        expect_sig("sim_enq_ptr", SigEnqPtr, 4);
        expect_sig("sim_wren", SigWren, 8'h10);
        expect_sig("sim_deq_fire", SigDeqFire, 1);
        expect_sig("sim_deq_ptr", SigDeqPtr, 1);
        expect_sig("sim_clear", SigClear, 8'h02);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("sim_valid", SigValid, 8'h1D);
        expect_sig("sim_count", SigCount, 4);
        cycle();

        // Drain down to valid = 0x01
        for (int i = 2; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(1 << i), 1'b1);
            expect_sig($sformatf("drain_fire%0d", i), SigDeqFire, 1);
            expect_sig($sformatf("drain_ptr%0d", i), SigDeqPtr, i);
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("drain_valid", SigValid, 8'h01);
        expect_sig("drain_count", SigCount, 1);
        cycle();

        // Illegal multi-hot selection
        drive(1'b0, 1'b0, 1'b1, 8'h06, 1'b1);
        expect_sig("perr_deq_fire", SigDeqFire, 0);
        expect_sig("perr_clear", SigClear, 0);
        expect_sig("perr_err_pre", SigErr, 0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_sig("perr_err_set", SigErr, 1);
        expect_sig("perr_valid", SigValid, 8'h01);
        cycle();
        expect_sig("perr_err_sticky", SigErr, 1);
        cycle();

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        expect_sig("arst_valid", SigValid, 0);
        expect_sig("arst_count", SigCount, 0);
        expect_sig("arst_err", SigErr, 0);
        expect_sig("arst_enq_ready", SigEnqReady, 1);
        expect_sig("arst_empty", SigEmpty, 1);
        @(negedge clock);
        drain();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
